// File: rtl/aether_pifo_cmd_sched.sv
// ---------------------------------------------------------------------------
// aether_pifo_cmd_sched
//
// Root command scheduler for an Aether PIFO tree. Merges push requests from
// NREQ requesters and a single pop requester onto the one root-node command
// port. Pop wins over push, and pushes are picked round-robin. Consecutive
// root commands are spaced at least ISSUE_GAP cycles apart. The block tracks
// tree occupancy so that it refuses pushes when the tree is full and pops when
// it is empty. Pop data read from the root is returned POP_LAT+2 cycles after
// the pop is accepted.
//
// Ports
//   i_clk, i_arst_n          clock, asynchronous active-low reset
//   i_push_valid/i_push_data per-requester push request; requester k uses
//                            i_push_data[k*(MTW+PTW) +: MTW+PTW]
//   o_push_ready             one-hot push grant (combinational)
//   i_pop_valid/o_pop_ready  pop request and pop grant (combinational)
//   o_pop_rvalid/o_pop_rdata pop response strobe and data
//   o_n_valid/o_n_op/o_n_data registered root command (op 0=push, 1=pop)
//   i_n_pop_data             root head entry, sampled POP_LAT cycles after
//                            a pop command is driven
//   o_count/o_full/o_empty   tree occupancy
// ---------------------------------------------------------------------------
module aether_pifo_cmd_sched #(
    parameter int PTW       = 16,
    parameter int MTW       = 32,
    parameter int NREQ      = 4,
    parameter int CAPACITY  = 20,
    parameter int ISSUE_GAP = 2,
    parameter int POP_LAT   = 2,
    parameter int CW        = $clog2(CAPACITY + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_arst_n,
    input  logic [NREQ-1:0]           i_push_valid,
    input  logic [NREQ*(MTW+PTW)-1:0] i_push_data,
    output logic [NREQ-1:0]           o_push_ready,
    input  logic                      i_pop_valid,
    output logic                      o_pop_ready,
    output logic                      o_pop_rvalid,
    output logic [MTW+PTW-1:0]        o_pop_rdata,
    output logic                      o_n_valid,
    output logic                      o_n_op,
    output logic [MTW+PTW-1:0]        o_n_data,
    input  logic [MTW+PTW-1:0]        i_n_pop_data,
    output logic [CW-1:0]             o_count,
    output logic                      o_full,
    output logic                      o_empty
);

    localparam int EW  = MTW + PTW;
    localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CDW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

    logic [RRW-1:0]     rr_ptr;
    logic [RRW-1:0]     rr_next;
    logic [CDW-1:0]     cooldown;
    logic [POP_LAT-1:0] pop_pipe;
    logic [CW-1:0]      count;

    logic               can_issue;
    logic               pop_grant;
    logic               push_any;
    logic [RRW-1:0]     push_idx;
    logic [NREQ-1:0]    push_grant;
    logic [EW-1:0]      push_sel_data;
    int                 rr_j;

    // Grants are qualified by the reset pin itself so that the ready outputs
    // read 0 for the whole time reset is asserted, even with valids high.
    always_comb begin
        can_issue     = i_arst_n && (cooldown == '0);
        pop_grant     = can_issue && i_pop_valid && (count != '0);
        push_any      = 1'b0;
        push_idx      = '0;
        push_grant    = '0;
        rr_j          = 0;
        if (can_issue && !pop_grant && (count != CW'(CAPACITY))) begin
            for (int i = 0; i < NREQ; i++) begin
                // Wrap at NREQ rather than at a power of two.
                rr_j = int'(rr_ptr) + i;
                if (rr_j >= NREQ) begin
                    rr_j = rr_j - NREQ;
                end
                if (!push_any && i_push_valid[rr_j]) begin
                    push_any = 1'b1;
                    push_idx = RRW'(rr_j);
                end
            end
        end
        if (push_any) begin
            push_grant[push_idx] = 1'b1;
        end
        push_sel_data = i_push_data[int'(push_idx)*EW +: EW];
        if (int'(push_idx) == NREQ - 1) begin
            rr_next = '0;
        end else begin
            rr_next = push_idx + RRW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            rr_ptr       <= '0;
            cooldown     <= '0;
            count        <= '0;
            pop_pipe     <= '0;
            o_n_valid    <= 1'b0;
            o_n_op       <= 1'b0;
            o_n_data     <= '0;
            o_pop_rvalid <= 1'b0;
            o_pop_rdata  <= '0;
        end else begin
            o_n_valid <= pop_grant | push_any;
            o_n_op    <= pop_grant;
            o_n_data  <= push_any ? push_sel_data : '0;

            if (pop_grant || push_any) begin
                cooldown <= CDW'(ISSUE_GAP - 1);
            end else if (cooldown != '0) begin
                cooldown <= cooldown - CDW'(1);
            end

            // Pop and push are mutually exclusive, so one adjust suffices.
            if (push_any) begin
                count  <= count + CW'(1);
                rr_ptr <= rr_next;
            end else if (pop_grant) begin
                count <= count - CW'(1);
            end

            // One stage per cycle of root read latency; the last stage marks
            // the cycle in which the root head is valid on i_n_pop_data.
            pop_pipe[0] <= o_n_valid & o_n_op;
            for (int i = 1; i < POP_LAT; i++) begin
                pop_pipe[i] <= pop_pipe[i-1];
            end

            o_pop_rvalid <= pop_pipe[POP_LAT-1];
            if (pop_pipe[POP_LAT-1]) begin
                o_pop_rdata <= i_n_pop_data;
            end
        end
    end

    assign o_push_ready = push_grant;
    assign o_pop_ready  = pop_grant;
    assign o_count      = count;
    assign o_full       = (count == CW'(CAPACITY));
    assign o_empty      = (count == '0);

endmodule

// File: tb/tb_aether_pifo_cmd_sched.sv
// ---------------------------------------------------------------------------
// tb_aether_pifo_cmd_sched
//
// Directed bench for aether_pifo_cmd_sched with default parameters
// (NREQ=4, CAPACITY=20, ISSUE_GAP=2, POP_LAT=2). Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_aether_pifo_cmd_sched;

    localparam int PTW  = 16;
    localparam int MTW  = 32;
    localparam int EW   = MTW + PTW;
    localparam int NREQ = 4;
    localparam int CW   = 5;

    logic              clk;
    logic              arst_n;
    logic [NREQ-1:0]   push_valid;
    logic [NREQ*EW-1:0] push_data;
    logic [NREQ-1:0]   push_ready;
    logic              pop_valid;
    logic              pop_ready;
    logic              pop_rvalid;
    logic [EW-1:0]     pop_rdata;
    logic              n_valid;
    logic              n_op;
    logic [EW-1:0]     n_data;
    logic [EW-1:0]     n_pop_data;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;

    int n_checks = 0;
    int n_fail   = 0;

    aether_pifo_cmd_sched dut (
        .i_clk        (clk),
        .i_arst_n     (arst_n),
        .i_push_valid (push_valid),
        .i_push_data  (push_data),
        .o_push_ready (push_ready),
        .i_pop_valid  (pop_valid),
        .o_pop_ready  (pop_ready),
        .o_pop_rvalid (pop_rvalid),
        .o_pop_rdata  (pop_rdata),
        .o_n_valid    (n_valid),
        .o_n_op       (n_op),
        .o_n_data     (n_data),
        .i_n_pop_data (n_pop_data),
        .o_count      (count),
        .o_full       (full),
        .o_empty      (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [EW-1:0] rr_data(input int k);
        logic [EW-1:0] d;
        d = {32'hC0DE_0000 + 32'(k), 16'h0010 + 16'(k)};
        return d;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        push_valid = '0;
        pop_valid  = 1'b0;
        arst_n     = 1'b0;
        @(posedge clk); #1;
        arst_n = 1'b1;
    endtask

    // Hold a push on requester k until granted; returns 1 ns into the cycle
    // after the transfer edge.
    task automatic push_one(input int k, input logic [EW-1:0] d);
        bit got;
        got = 0;
        push_data[k*EW +: EW] = d;
        push_valid[k] = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (push_ready[k]) got = 1;
            @(posedge clk); #1;
        end
        push_valid[k] = 1'b0;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL push_timeout: requester %0d not granted within 20 cycles (count=%0d)", k, count);
        end
    endtask

    task automatic pop_one();
        bit got;
        got = 0;
        pop_valid = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (pop_ready) got = 1;
            @(posedge clk); #1;
        end
        pop_valid = 1'b0;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL pop_timeout: pop not granted within 20 cycles (count=%0d)", count);
        end
    endtask

    task automatic test_reset();
        arst_n     = 1'b0;
        push_valid = '1;
        pop_valid  = 1'b1;
        push_data  = '0;
        n_pop_data = 48'h1111_2222_3333;
        #3;
        n_checks++;
        if (push_ready !== 4'b0000) begin
            n_fail++; $display("FAIL por_push_ready: got %b expected 0000", push_ready);
        end
        n_checks++;
        if (pop_ready !== 1'b0) begin
            n_fail++; $display("FAIL por_pop_ready: got %b expected 0", pop_ready);
        end
        n_checks++;
        if ({n_valid, n_op, n_data} !== 50'd0) begin
            n_fail++; $display("FAIL por_n_cmd: got v=%b op=%b d=%h expected all 0", n_valid, n_op, n_data);
        end
        n_checks++;
        if ({pop_rvalid, pop_rdata} !== 49'd0) begin
            n_fail++; $display("FAIL por_pop_resp: got v=%b d=%h expected all 0", pop_rvalid, pop_rdata);
        end
        n_checks++;
        if (count !== 5'd0 || full !== 1'b0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL por_occupancy: got count=%0d full=%b empty=%b expected 0/0/1", count, full, empty);
        end
        push_valid = '0;
        pop_valid  = 1'b0;
        @(posedge clk); #1;
        arst_n = 1'b1;
    endtask

    task automatic test_single_push();
        do_reset();
        push_data[2*EW +: EW] = 48'hA5A5_A5A5_0005;
        push_valid = 4'b0100;
        @(negedge clk);
        n_checks++;
        if (push_ready !== 4'b0100) begin
            n_fail++; $display("FAIL single_push_ready: got %b expected 0100", push_ready);
        end
        @(posedge clk); #1;
        push_valid = '0;
        @(negedge clk);
        n_checks++;
        if (n_valid !== 1'b1 || n_op !== 1'b0 || n_data !== 48'hA5A5_A5A5_0005) begin
            n_fail++; $display("FAIL single_push_cmd: got v=%b op=%b d=%h expected 1/0/a5a5a5a50005", n_valid, n_op, n_data);
        end
        n_checks++;
        if (count !== 5'd1 || empty !== 1'b0) begin
            n_fail++; $display("FAIL single_push_count: got count=%0d empty=%b expected 1/0", count, empty);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (n_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_push_one_shot: got n_valid=%b expected 0", n_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_rdy;
        do_reset();
        for (int k = 0; k < NREQ; k++) push_data[k*EW +: EW] = rr_data(k);
        push_valid = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            exp_rdy = (c % 2 == 0) ? 4'(1 << ((c / 2) % 4)) : 4'b0000;
            n_checks++;
            if (push_ready !== exp_rdy) begin
                n_fail++; $display("FAIL rr_ready_c%0d: got %b expected %b", c, push_ready, exp_rdy);
            end
            n_checks++;
            if (n_valid !== (c % 2 == 1)) begin
                n_fail++; $display("FAIL rr_n_valid_c%0d: got %b expected %b", c, n_valid, (c % 2 == 1));
            end
            if (c % 2 == 1) begin
                n_checks++;
                if (n_op !== 1'b0 || n_data !== rr_data(((c - 1) / 2) % 4)) begin
                    n_fail++; $display("FAIL rr_n_data_c%0d: got op=%b d=%h expected 0/%h", c, n_op, n_data, rr_data(((c - 1) / 2) % 4));
                end
            end
            @(posedge clk); #1;
        end
        push_valid = '0;
        @(negedge clk);
        n_checks++;
        if (count !== 5'd5) begin
            n_fail++; $display("FAIL rr_count: got %0d expected 5", count);
        end
    endtask

    task automatic test_pop_priority();
        bit got;
        do_reset();
        n_pop_data = 48'hDEAD_BEEF_7777;
        push_one(0, 48'h0000_0001_0001);
        push_one(0, 48'h0000_0002_0002);
        push_one(0, 48'h0000_0003_0003);
        @(negedge clk);
        n_checks++;
        if (count !== 5'd3) begin
            n_fail++; $display("FAIL prio_setup_count: got %0d expected 3", count);
        end
        @(posedge clk); #1;
        push_data[1*EW +: EW] = 48'h1234_5678_0009;
        push_valid = 4'b0010;
        pop_valid  = 1'b1;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (pop_ready) got = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        n_checks++;
        if (!got || push_ready !== 4'b0000) begin
            n_fail++; $display("FAIL prio_pop_first: got pop_ready=%b push_ready=%b expected 1/0000", got, push_ready);
        end
        @(posedge clk); #1;
        pop_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (n_valid !== 1'b1 || n_op !== 1'b1 || n_data !== 48'd0 || count !== 5'd2) begin
            n_fail++; $display("FAIL prio_pop_cmd: got v=%b op=%b d=%h count=%0d expected 1/1/0/2", n_valid, n_op, n_data, count);
        end
        n_checks++;
        if (push_ready !== 4'b0000) begin
            n_fail++; $display("FAIL prio_gap_ready: got %b expected 0000", push_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (push_ready !== 4'b0010 || pop_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL prio_push_next: got ready=%b rvalid=%b expected 0010/0", push_ready, pop_rvalid);
        end
        @(posedge clk); #1;
        push_valid = '0;
        n_pop_data = 48'h0000_0000_0003;
        @(negedge clk);
        n_checks++;
        if (n_valid !== 1'b1 || n_op !== 1'b0 || n_data !== 48'h1234_5678_0009 || pop_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL prio_push_cmd: got v=%b op=%b d=%h rvalid=%b expected 1/0/123456780009/0", n_valid, n_op, n_data, pop_rvalid);
        end
        @(posedge clk); #1;
        n_pop_data = 48'hDEAD_BEEF_7777;
        @(negedge clk);
        n_checks++;
        if (pop_rvalid !== 1'b1 || pop_rdata !== 48'h0000_0000_0003) begin
            n_fail++; $display("FAIL prio_pop_resp: got rvalid=%b rdata=%h expected 1/000000000003", pop_rvalid, pop_rdata);
        end
        n_checks++;
        if (count !== 5'd3) begin
            n_fail++; $display("FAIL prio_count: got %0d expected 3", count);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (pop_rvalid !== 1'b0 || pop_rdata !== 48'h0000_0000_0003) begin
            n_fail++; $display("FAIL prio_resp_hold: got rvalid=%b rdata=%h expected 0/000000000003", pop_rvalid, pop_rdata);
        end
    endtask

    task automatic test_midstream_reset();
        for (int k = 0; k < NREQ; k++) push_data[k*EW +: EW] = rr_data(k);
        push_valid = 4'b1111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        arst_n = 1'b0;
        #1;
        n_checks++;
        if (push_ready !== 4'b0000 || pop_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_ready: got push=%b pop=%b expected 0000/0", push_ready, pop_ready);
        end
        n_checks++;
        if (n_valid !== 1'b0 || n_data !== 48'd0 || pop_rvalid !== 1'b0 || pop_rdata !== 48'd0) begin
            n_fail++; $display("FAIL mid_rst_outputs: got nv=%b nd=%h rv=%b rd=%h expected all 0", n_valid, n_data, pop_rvalid, pop_rdata);
        end
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_occupancy: got count=%0d empty=%b full=%b expected 0/1/0", count, empty, full);
        end
        push_valid = '0;
        @(posedge clk); #1;
        arst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (n_valid !== 1'b0) begin
                n_fail++; $display("FAIL mid_rst_idle_c%0d: got n_valid=%b expected 0", c, n_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_full_empty();
        do_reset();
        for (int i = 0; i < 20; i++) push_one(i % NREQ, rr_data(i));
        @(negedge clk);
        n_checks++;
        if (count !== 5'd20 || full !== 1'b1 || empty !== 1'b0) begin
            n_fail++; $display("FAIL full_flags: got count=%0d full=%b empty=%b expected 20/1/0", count, full, empty);
        end
        @(posedge clk); #1;
        push_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (push_ready !== 4'b0000) begin
                n_fail++; $display("FAIL full_push_blocked_c%0d: got %b expected 0000", c, push_ready);
            end
            @(posedge clk); #1;
        end
        pop_one();
        push_valid = '0;
        @(negedge clk);
        n_checks++;
        if (count !== 5'd19 || full !== 1'b0) begin
            n_fail++; $display("FAIL full_pop_accepted: got count=%0d full=%b expected 19/0", count, full);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 19; i++) pop_one();
        @(negedge clk);
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL empty_flags: got count=%0d empty=%b expected 0/1", count, empty);
        end
        @(posedge clk); #1;
        pop_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (pop_ready !== 1'b0) begin
                n_fail++; $display("FAIL empty_pop_blocked_c%0d: got %b expected 0", c, pop_ready);
            end
            @(posedge clk); #1;
        end
        push_valid = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (push_ready !== 4'b0001 || pop_ready !== 1'b0) begin
            n_fail++; $display("FAIL empty_push_ok: got push=%b pop=%b expected 0001/0", push_ready, pop_ready);
        end
        @(posedge clk); #1;
        push_valid = '0;
        pop_valid  = 1'b0;
    endtask

    task automatic test_reset_during_pop();
        do_reset();
        n_pop_data = 48'hFEED_FACE_0042;
        push_one(0, 48'h0000_00AA_0001);
        pop_one();
        @(negedge clk);
        n_checks++;
        if (n_valid !== 1'b1 || n_op !== 1'b1) begin
            n_fail++; $display("FAIL rdp_pop_issued: got v=%b op=%b expected 1/1", n_valid, n_op);
        end
        @(posedge clk); #1;
        arst_n = 1'b0;
        @(posedge clk); #1;
        arst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (pop_rvalid !== 1'b0 || n_valid !== 1'b0) begin
                n_fail++; $display("FAIL rdp_no_resp_c%0d: got rvalid=%b n_valid=%b expected 0/0", c, pop_rvalid, n_valid);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL rdp_count: got count=%0d empty=%b expected 0/1", count, empty);
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_round_robin();
        test_pop_priority();
        test_midstream_reset();
        test_full_empty();
        test_reset_during_pop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aether_pifo_cmd_sched.md
# aether_pifo_cmd_sched

Command scheduler for the root of an Aether PIFO tree. It arbitrates push requests from `NREQ` requesters and one pop requester onto the single root-node command port, and enforces the minimum issue spacing the 2-stage pipelined nodes require. It tracks total tree occupancy to block pushes when the tree is full and pops when it is empty. It returns pop data to the requester after a fixed latency.

## Interface
Parameters:
- `PTW`, 16, priority tag width (low bits of an entry)
- `MTW`, 32, metadata width (high bits of an entry)
- `NREQ`, 4, number of push requesters, ≥1
- `CAPACITY`, 20, total entries the tree can hold
- `ISSUE_GAP`, 2, minimum cycles between consecutive root commands, ≥1
- `POP_LAT`, 2, cycles from pop issue on `o_n_valid` to `i_n_pop_data` sampling, ≥1
- `CW`, `$clog2(CAPACITY+1)`, count width (derived)

Ports:
- `i_clk`  in  1  clock; all logic on posedge
- `i_arst_n`  in  1  reset, asynchronous, active-low
- `i_push_valid`  in  NREQ  per-requester push request
- `i_push_data`  in  NREQ*(MTW+PTW)  requester k occupies bits [k*(MTW+PTW) +: MTW+PTW]
- `o_push_ready`  out  NREQ  one-hot grant; transfer when valid&ready
- `i_pop_valid`  in  1  pop request
- `o_pop_ready`  out  1  pop grant
- `o_pop_rvalid`  out  1  one-cycle pop response strobe
- `o_pop_rdata`  out  MTW+PTW  pop response data
- `o_n_valid`  out  1  root command valid (registered)
- `o_n_op`  out  1  0 = push, 1 = pop
- `o_n_data`  out  MTW+PTW  push entry; 0 for pop
- `i_n_pop_data`  in  MTW+PTW  root head entry
- `o_count`  out  CW  accepted pushes minus accepted pops
- `o_full`  out  1  `o_count == CAPACITY`
- `o_empty`  out  1  `o_count == 0`

## Operation
- Per cycle, the block grants at most one request. Grant is combinational from registered state plus the valids. Ready may depend on valid.
- The block grants only when the issue cooldown is 0.
- Pop has priority over push. Pop is eligible when `i_pop_valid` is high and `o_count > 0`.
- Push is eligible when no pop is granted and `o_count < CAPACITY`.
- Push arbitration is round-robin. The search starts at `rr_ptr`. After a grant to k, `rr_ptr` becomes (k+1) mod NREQ. `rr_ptr` does not change when no push is granted.
- On accept at edge t:
  - `o_n_valid`, `o_n_op` and `o_n_data` are driven in cycle t+1 for exactly one cycle.
  - Cooldown loads ISSUE_GAP-1.
  - `o_count` is updated at the same edge: +1 on push, -1 on pop. Both can never happen in one cycle.
- Cooldown decrements each cycle while nonzero. With ISSUE_GAP=1, the block can grant every cycle.
- Pop tracking uses a POP_LAT-deep shift register of in-flight pops, so multiple pops can be outstanding. When a pop issued on `o_n_valid` in cycle u reaches the end:
  - `i_n_pop_data` is sampled at cycle u+POP_LAT.
  - `o_pop_rdata` is registered from that sample.
  - `o_pop_rvalid` is high in cycle u+POP_LAT+1.
  - `o_pop_rdata` holds its value until the next response.
- Requesters must hold valid and data until ready. The block never drops a request.
- Width rules:
  - `o_count` saturates by construction: no push at CAPACITY, no pop at 0.
  - `rr_ptr` is `$clog2(NREQ)` bits wide and wraps at NREQ, not at a power of two.

## Timing
- Reset values:
  - `o_push_ready` = 0, `o_pop_ready` = 0
  - `o_n_valid` = 0, `o_n_op` = 0, `o_n_data` = 0
  - `o_pop_rvalid` = 0, `o_pop_rdata` = 0
  - `o_count` = 0, `o_full` = 0, `o_empty` = 1
  - `rr_ptr` = 0, cooldown = 0, pop pipeline cleared
- Reset mid-operation clears all state immediately. In-flight pop responses are discarded: `o_pop_rvalid` never fires for them.
- Latencies:
  - accept → `o_n_valid`: 1 cycle
  - pop accept → `o_pop_rvalid`: POP_LAT+2 cycles
  - accept → `o_count`/`o_full`/`o_empty` change: visible the next cycle
- Boundaries:
  - At `o_count == CAPACITY`, all `o_push_ready` are 0. Pop is still grantable.
  - At `o_count == 0`, `o_pop_ready` is 0. Pushes are still grantable.
  - A simultaneous pop and push at CAPACITY grants the pop; the push is granted at the next eligible slot.

## Test plan
- Reset: assert `i_arst_n`=0 mid-stream → all outputs at their reset values within the same cycle, `o_empty`=1, no `o_n_valid` after release until a new request.
- Single push: req 2 valid with data prio 0x0005, meta 0xA5A5A5A5 → `o_push_ready`=4'b0100 that cycle, `o_n_valid`=1 / `o_n_op`=0 / `o_n_data`={0xA5A5A5A5,0x0005} next cycle, `o_count`=1.
- Round-robin with spacing: all 4 requesters held valid → grants 0,1,2,3,0 on cycles t, t+2, t+4, t+6, t+8, with no `o_n_valid` in the gap cycles.
- Pop priority: `o_count`=3, pop and req 1 push both valid → pop granted first, push granted 2 cycles later; with `i_n_pop_data`=0x...0003 at issue+2, `o_pop_rvalid`=1 with that data at issue+3.
- Full/empty: 20 pushes → `o_full`=1 and all `o_push_ready`=0 while pushes stay pending; a pop is still accepted. Then drain with 20 pops → `o_empty`=1 and `o_pop_ready`=0 while pop is pending.
- Reset during pop: pop issued, reset asserted at issue+1 → `o_pop_rvalid` stays 0 and `o_count`=0 after release.
